qduc_sched: RTL and testbench

Sample scheduler for the quadrature digital up-converter: accepts I/Q baseband samples from an upstream source over a valid/ready handshake and buffers them in a small FIFO. It releases them to the DUC datapath at exactly one sample per interpolation period, with a one-cycle strobe that serves as the DUC input clock enable. It replaces the free-running clock divider in front of the CIC interpolators. It also handles start/stop sequencing, FIFO priming and underflow reporting.

---
 rtl/qduc_pkg.sv | 12 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/qduc_sched.sv | 151 +++++++++++++++
 tb/tb_qduc_sched.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qduc_pkg.sv
// Shared definitions for the quadrature DUC: scheduler state encoding and default sample width.
package qduc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } qduc_state_t;

    localparam int QDUC_ISZ = 16;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy output and a synchronous flush.
module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clr,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_data,
    output logic [W-1:0]             o_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;
    logic         w_wr_en;
    logic         w_rd_en;

    assign w_wr_en = i_push && !o_full;
    assign w_rd_en = i_pop && !o_empty;

    // NOTE: the storage array is deliberately left out of reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else if (i_clr) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_wr_en) r_wr <= r_wr + 1'b1;
            if (w_rd_en) r_rd <= r_rd + 1'b1;
        end
    end

    assign o_level = r_wr - r_rd;
    assign o_full  = (o_level == (AW+1)'(DEPTH));
    assign o_empty = (r_wr == r_rd);
    assign o_data  = r_mem[r_rd[AW-1:0]];

endmodule

// File: rtl/qduc_sched.sv
// Releases buffered I/Q samples to the DUC at one sample per interpolation period,
// with start/stop sequencing, FIFO priming and sticky underflow reporting.
module qduc_sched
    import qduc_pkg::*;
#(
    parameter int ISZ   = QDUC_ISZ,
    parameter int DEPTH = 8,
    parameter int PRIME = 4,
    parameter int RW    = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [RW-1:0]                ratio,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic signed [ISZ-1:0]        s_i,
    input  logic signed [ISZ-1:0]        s_q,
    output logic                         duc_strobe,
    output logic signed [ISZ-1:0]        duc_i,
    output logic signed [ISZ-1:0]        duc_q,
    output logic                         running,
    output logic                         underflow,
    input  logic                         underflow_clr,
    output logic [$clog2(DEPTH):0]       level
);
    localparam int LW = $clog2(DEPTH) + 1;

    qduc_state_t           r_state;
    qduc_state_t           w_state_nxt;
    logic [RW-1:0]         r_cnt;
    logic [RW-1:0]         w_cnt_nxt;
    logic [RW-1:0]         r_ratio;
    logic [RW-1:0]         w_ratio_nxt;
    logic                  r_stop;
    logic                  w_stop_nxt;
    logic                  r_strobe;
    logic signed [ISZ-1:0] r_i;
    logic signed [ISZ-1:0] r_q;
    logic                  r_underflow;
    logic                  w_load;
    logic                  w_pop;
    logic                  w_uflow;
    logic                  w_push;
    logic                  w_flush;
    logic                  w_full;
    logic                  w_empty;
    logic [2*ISZ-1:0]      w_head;
    logic [LW-1:0]         w_level;

    // The output registers are loaded one cycle ahead, so the decision uses the
    // counter value the next cycle will hold; data is then valid with the strobe.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ratio_nxt = r_ratio;
        w_stop_nxt  = r_stop;
        w_load      = 1'b0;
        w_pop       = 1'b0;
        w_uflow     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt  = '0;
                w_stop_nxt = 1'b0;
                if (enable) w_state_nxt = ST_PRIME;
            end
            ST_PRIME: begin
                w_stop_nxt = 1'b0;
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_level >= LW'(PRIME)) begin
                    w_state_nxt = ST_RUN;
                    w_ratio_nxt = ratio;
                    w_cnt_nxt   = '0;
                    w_load      = (ratio == '0);
                end
            end
            ST_RUN: begin
                w_cnt_nxt  = (r_cnt == r_ratio) ? '0 : r_cnt + 1'b1;
                w_stop_nxt = r_stop || !enable;
                w_load     = (w_cnt_nxt == r_ratio);
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_load) begin
            if (w_stop_nxt) begin
                w_state_nxt = ST_IDLE;
            end else if (w_empty) begin
                w_uflow     = 1'b1;
                w_state_nxt = ST_PRIME;
            end else begin
                w_pop = 1'b1;
            end
        end
    end

    assign w_flush = (w_state_nxt == ST_IDLE);
    assign s_ready = (r_state != ST_IDLE) && !w_full;
    assign w_push  = s_valid && s_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ratio     <= '0;
            r_stop      <= 1'b0;
            r_strobe    <= 1'b0;
            r_i         <= '0;
            r_q         <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ratio  <= w_ratio_nxt;
            r_stop   <= w_stop_nxt;
            r_strobe <= w_load;
            if (w_load) begin
                r_i <= w_pop ? w_head[2*ISZ-1:ISZ] : '0;
                r_q <= w_pop ? w_head[ISZ-1:0]     : '0;
            end
            // A new underflow wins over a simultaneous clear.
            r_underflow <= w_uflow || (r_underflow && !underflow_clr);
        end
    end

    sync_fifo #(
        .W     (2*ISZ),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_clr   (w_flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({s_i, s_q}),
        .o_data  (w_head),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign duc_strobe = r_strobe;
    assign duc_i      = r_i;
    assign duc_q      = r_q;
    assign running    = (r_state == ST_RUN);
    assign underflow  = r_underflow;
    assign level      = w_level;

endmodule

// File: tb/tb_qduc_sched.sv
// Directed bench for qduc_sched: table of streaming cases plus stop, ratio-latch and async-reset sequences.
module tb_qduc_sched;

    logic               clk;
    logic               reset;
    logic               enable;
    logic [7:0]         ratio;
    logic               s_valid;
    logic               s_ready;
    logic signed [15:0] s_i;
    logic signed [15:0] s_q;
    logic               duc_strobe;
    logic signed [15:0] duc_i;
    logic signed [15:0] duc_q;
    logic               running;
    logic               underflow;
    logic               underflow_clr;
    logic [3:0]         level;

    qduc_sched #(
        .ISZ   (16),
        .DEPTH (8),
        .PRIME (4),
        .RW    (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .ratio         (ratio),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_i           (s_i),
        .s_q           (s_q),
        .duc_strobe    (duc_strobe),
        .duc_i         (duc_i),
        .duc_q         (duc_q),
        .running       (running),
        .underflow     (underflow),
        .underflow_clr (underflow_clr),
        .level         (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ratio;
        int nsamp;
        int exp_per;
        int exp_max_lvl;
    } vec_t;

    int n_vec;
    int n_err;
    int cyc;
    int push_idx;
    int push_n;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: inputs change #1 after posedge, outputs are inspected at the following negedge.
    task automatic cycle();
        bit take;
        take = s_valid && s_ready;
        @(posedge clk);
        #1;
        if (take) push_idx++;
        s_valid = (push_idx < push_n);
        s_i     = 16'(100 * (push_idx + 1));
        s_q     = -s_i;
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        enable        = 1'b0;
        s_valid       = 1'b0;
        underflow_clr = 1'b0;
        ratio         = 8'd0;
        push_n        = 0;
        push_idx      = 0;
        repeat (2) cycle();
        reset = 1'b1;
        cycle();
    endtask

    task automatic run_case(input vec_t v);
        int  strobes;
        int  rise_cyc;
        int  last_cyc;
        int  max_lvl;
        int  budget;
        bit  done;
        bit  seen_rise;
        logic prev_run;
        do_reset();
        ratio     = 8'(v.ratio);
        enable    = 1'b1;
        push_n    = v.nsamp;
        strobes   = 0;
        rise_cyc  = 0;
        last_cyc  = 0;
        max_lvl   = 0;
        done      = 1'b0;
        seen_rise = 1'b0;
        prev_run  = 1'b0;
        budget    = (v.nsamp + 3) * v.exp_per + 40;
        for (int c = 0; c < budget && !done; c++) begin
            cycle();
            if (int'(level) > max_lvl) max_lvl = int'(level);
            if (level == 4'd8) check("ready_at_full", s_ready, 0);
            if (running && !prev_run && !seen_rise) begin
                seen_rise = 1'b1;
                rise_cyc  = cyc;
            end
            prev_run = running;
            if (duc_strobe) begin
                if (strobes == 0) check("first_strobe_delay", cyc - rise_cyc, v.exp_per - 1);
                else              check("strobe_period", cyc - last_cyc, v.exp_per);
                last_cyc = cyc;
                if (strobes < v.nsamp) begin
                    check("duc_i", int'(duc_i), 100 * (strobes + 1));
                    check("duc_q", int'(duc_q), -100 * (strobes + 1));
                end else begin
                    check("uf_duc_i", int'(duc_i), 0);
                    check("uf_duc_q", int'(duc_q), 0);
                    check("uf_flag", underflow, 1);
                    check("uf_running", running, 0);
                    done = 1'b1;
                end
                strobes++;
            end
        end
        check("underflow_reached", done, 1);
        check("max_level", max_lvl, v.exp_max_lvl);
        underflow_clr = 1'b1;
        cycle();
        underflow_clr = 1'b0;
        check("uf_cleared", underflow, 0);
        check("prime_ready", s_ready, 1);
    endtask

    initial begin
        vec_t tbl[4];
        int   strobes;
        int   last_cyc;
        int   cnt;
        bit   found;

        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        tbl[0] = '{ratio: 3,   nsamp: 4,  exp_per: 4,   exp_max_lvl: 4};
        tbl[1] = '{ratio: 0,   nsamp: 8,  exp_per: 1,   exp_max_lvl: 4};
        tbl[2] = '{ratio: 3,   nsamp: 6,  exp_per: 4,   exp_max_lvl: 6};
        tbl[3] = '{ratio: 255, nsamp: 12, exp_per: 256, exp_max_lvl: 8};

        // Reset and idle behaviour
        reset         = 1'b0;
        enable        = 1'b0;
        ratio         = 8'd0;
        s_valid       = 1'b0;
        s_i           = '0;
        s_q           = '0;
        underflow_clr = 1'b0;
        push_n        = 0;
        push_idx      = 0;
        repeat (2) cycle();
        check("rst_strobe", duc_strobe, 0);
        check("rst_duc_i", int'(duc_i), 0);
        check("rst_duc_q", int'(duc_q), 0);
        check("rst_running", running, 0);
        check("rst_underflow", underflow, 0);
        check("rst_level", level, 0);
        check("rst_ready", s_ready, 0);
        reset = 1'b1;
        cnt   = 0;
        repeat (20) begin
            cycle();
            if (duc_strobe || s_ready || running || level != 4'd0) cnt++;
        end
        check("idle_quiet_cycles", cnt, 0);

        for (int k = 0; k < 4; k++) run_case(tbl[k]);

        // Stop in mid-period: one zero strobe at the boundary, no pop, then IDLE with a flushed FIFO
        do_reset();
        ratio   = 8'd3;
        enable  = 1'b1;
        push_n  = 8;
        strobes = 0;
        last_cyc = 0;
        for (int c = 0; c < 40 && strobes < 2; c++) begin
            cycle();
            if (duc_strobe) begin
                strobes++;
                last_cyc = cyc;
            end
        end
        check("stop_pre_strobes", strobes, 2);
        check("stop_pre_data", int'(duc_i), 200);
        cycle();
        enable = 1'b0;
        found  = 1'b0;
        for (int c = 0; c < 12 && !found; c++) begin
            cycle();
            if (duc_strobe) begin
                found = 1'b1;
                check("stop_period", cyc - last_cyc, 4);
                check("stop_duc_i", int'(duc_i), 0);
                check("stop_duc_q", int'(duc_q), 0);
                check("stop_level", level, 0);
                check("stop_running", running, 0);
                check("stop_underflow", underflow, 0);
            end
        end
        check("stop_strobe_seen", found, 1);
        cnt = 0;
        repeat (10) begin
            cycle();
            if (duc_strobe) cnt++;
        end
        check("stop_no_more_strobes", cnt, 0);
        check("stop_idle_ready", s_ready, 0);

        // Ratio change during RUN is ignored; async reset mid-period clears outputs at once
        do_reset();
        ratio   = 8'd3;
        enable  = 1'b1;
        push_n  = 8;
        strobes = 0;
        last_cyc = 0;
        for (int c = 0; c < 60 && strobes < 3; c++) begin
            cycle();
            if (duc_strobe) begin
                if (strobes == 0) begin
                    ratio = 8'd7;
                end else begin
                    check("latch_period", cyc - last_cyc, 4);
                    check("latch_duc_i", int'(duc_i), 100 * (strobes + 1));
                end
                last_cyc = cyc;
                strobes++;
            end
        end
        check("latch_strobes", strobes, 3);
        cycle();
        check("pre_reset_duc_i", int'(duc_i), 300);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_duc_i", int'(duc_i), 0);
        check("async_rst_duc_q", int'(duc_q), 0);
        check("async_rst_strobe", duc_strobe, 0);
        check("async_rst_running", running, 0);
        check("async_rst_level", level, 0);
        check("async_rst_ready", s_ready, 0);
        cnt = 0;
        repeat (10) begin
            cycle();
            if (duc_strobe) cnt++;
        end
        check("rst_no_strobes", cnt, 0);
        reset = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
